// File: rtl/dma_out_buffer.sv
// -----------------------------------------------------------------------------
// dma_out_buffer
//
// Result-side buffer between the VAE forward datapath and the PYNQ S2MM DMA
// channel. The datapath writes MEM_DEPTH result words by address into a local
// memory while the block is idle. A single-cycle start pulse then streams the
// words out in ascending address order on an AXI-Stream master interface,
// with TLAST marking the final word.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   rst            synchronous reset, active-high (memory is not cleared)
//   wr_en          write strobe from the datapath
//   wr_addr        write address
//   wr_data        write data
//   start          single-cycle request to begin streaming
//   m_axis_tdata   stream data (registered)
//   m_axis_tvalid  stream valid
//   m_axis_tready  DMA ready
//   m_axis_tlast   high with the final word
//   busy           high while loading or sending
//   done           one-cycle pulse after the last handshake
//   wr_err         one-cycle pulse the cycle after a rejected write
// -----------------------------------------------------------------------------
module dma_out_buffer #(
    parameter int MEM_DEPTH  = 5,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   next_ptr;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    wr_accept;
    logic                    handshake;
    logic                    last_beat;

    // Writes land only while idle and only inside the populated address range.
    assign wr_accept = wr_en && (state == IDLE) && (wr_addr <= LAST_ADDR);
    assign handshake = m_axis_tvalid && m_axis_tready;
    assign last_beat = (rd_ptr == LAST_ADDR);
    assign next_ptr  = rd_ptr + ADDR_WIDTH'(1);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment ahead of the case keeps every path driven,
    // so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = SEND;
            SEND: if (handshake && last_beat) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State-decoded outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            LOAD, SEND: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Result memory
    // -------------------------------------------------------------------------
    // NOTE: the memory has no reset on purpose; results written before a
    // reset stay valid and the array maps cleanly onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Stream datapath, read pointer and write-error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_accept;

            unique case (state)
                IDLE: begin
                    if (start) rd_ptr <= '0;
                end
                LOAD: begin
                    // Memory write from the start cycle has committed by now,
                    // so word 0 already reflects it.
                    m_axis_tdata  <= mem[0];
                    m_axis_tvalid <= 1'b1;
                    m_axis_tlast  <= (MEM_DEPTH == 1);
                end
                SEND: begin
                    // Without a handshake nothing changes, which keeps the
                    // beat stable under backpressure.
                    if (handshake) begin
                        if (last_beat) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else begin
                            rd_ptr       <= next_ptr;
                            m_axis_tdata <= mem[next_ptr];
                            m_axis_tlast <= (next_ptr == LAST_ADDR);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dma_out_buffer.md
Name: dma_out_buffer

Overview:
- Result-side counterpart of the DMA dump memory buffer.
- The compute datapath writes MEM_DEPTH 64-bit result words by address into a local memory.
- On `start`, the block streams the words in ascending address order to the DMA engine over an AXI-Stream master interface, asserting TLAST on the final word.
- Sits between the VAE forward datapath output and the PYNQ S2MM DMA channel.

Parameters:
- MEM_DEPTH, 5, number of 64-bit words per transfer (must be ≥1).
- ADDR_WIDTH, 3, width of the address and read pointer; 2^ADDR_WIDTH ≥ MEM_DEPTH.
- DATA_WIDTH, 64, word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write strobe from the datapath.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- start  input  1  single-cycle request to begin streaming.
- m_axis_tdata  output  DATA_WIDTH  stream data (registered).
- m_axis_tvalid  output  1  stream valid.
- m_axis_tready  input  1  DMA ready.
- m_axis_tlast  output  1  high with the final word.
- busy  output  1  high in LOAD or SEND.
- done  output  1  one-cycle pulse after the last handshake.
- wr_err  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- Reset (rst=1 at posedge, any state):
  - State returns to IDLE; rd_ptr=0.
  - m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0, done=0, wr_err=0.
  - Memory contents are not cleared.
  - Reset mid-stream aborts the transfer immediately; no done pulse is issued.
- Writes:
  - Accepted only in IDLE, and only when wr_addr < MEM_DEPTH: mem[wr_addr] <= wr_data.
  - Rejected in any other state, or when wr_addr ≥ MEM_DEPTH. A rejected write pulses wr_err for one cycle, the cycle after the strobe, and leaves memory unchanged.
- State machine IDLE, LOAD, SEND, DONE:
  - IDLE: if start=1, go to LOAD and set rd_ptr=0. start seen in any other state is ignored. If start and an accepted wr_en occur in the same cycle, the write commits first and the streamed data includes it.
  - LOAD (exactly 1 cycle):
    - m_axis_tdata <= mem[0], m_axis_tvalid <= 1.
    - m_axis_tlast <= (MEM_DEPTH==1).
    - Next state SEND.
  - SEND:
    - All outputs are held stable while tvalid=1 and tready=0 (AXI-Stream rule; tvalid never drops without a handshake).
    - On a handshake (tvalid & tready) with rd_ptr == MEM_DEPTH-1: tvalid <= 0, tlast <= 0, go to DONE.
    - On any other handshake: rd_ptr <= rd_ptr+1, tdata <= mem[rd_ptr+1], tlast <= (rd_ptr+1 == MEM_DEPTH-1). tvalid stays 1, so back-to-back transfers run at one word per cycle when tready is held high.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- busy=1 in LOAD and SEND; 0 in IDLE and DONE.
- Latency:
  - Start at cycle t gives first tvalid at t+2: one cycle to register the state, one cycle in LOAD.
  - With tready held high, the last handshake falls at t+1+MEM_DEPTH and done pulses at t+2+MEM_DEPTH.
- Pointer arithmetic: rd_ptr is unsigned ADDR_WIDTH. It never exceeds MEM_DEPTH-1, so no wrap occurs.
- tlast is asserted only together with tvalid.

Test Plan:
- Basic stream: write mem[0..4]=64'h10..64'h14 in IDLE, then start; tready held 1.
  - Expect tvalid from start+2.
  - Expect tdata 0x10,0x11,0x12,0x13,0x14 on consecutive cycles, with tlast only on 0x14.
  - Expect done pulse 1 cycle after the last beat; busy low after that.
- Backpressure: same data, tready toggling 1,0,0,1,0,1,...
  - Each word is held stable while tready=0.
  - Exactly 5 handshakes occur, in order; tlast only on the 5th.
- Write rejection:
  - wr_en at wr_addr=5 in IDLE gives a wr_err pulse, and memory is unchanged; verify by streaming.
  - wr_en at addr 2 with data 0xAA during SEND gives wr_err, and the streamed word 2 keeps its old value.
- Same-cycle start and write: wr_en at addr 0 with data 0xFF in the same cycle as start. The first streamed word is 0xFF.
- Reset mid-transfer: assert rst after 2 handshakes.
  - Next cycle: tvalid=0, tlast=0, busy=0, and no done pulse.
  - A fresh start then streams from address 0 again with all 5 words intact.
- Start while busy: a second start pulse during SEND is ignored. Only 5 beats and one done pulse occur.
